// File: rtl/spi_pkg.sv
// spi_pkg: types and helpers shared by the SPI slave bit engine, its
// TX holding register and its handshake interface.
package spi_pkg;

  // Word length used when a block is instantiated without an override.
  localparam int SPI_DATA_W_DEFAULT = 8;

  // Bit-engine states: waiting for chip select, or inside a frame.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_e;

  // MOSI is sampled on the SCLK rising edge when CPOL and CPHA agree,
  // otherwise on the falling edge; the opposite edge drives MISO.
  function automatic bit sample_on_rise(input int cpol, input int cpha);
    return (cpol == cpha);
  endfunction

endpackage

// File: rtl/spi_slave_shifter_if.sv
// spi_slave_shifter_if: word-level link between the SPI bit engine and the
// register/command layer above it. RX is a bare valid pulse (no
// backpressure); TX is a valid/ready handshake into a one-word buffer.
interface spi_slave_shifter_if
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W_DEFAULT
);

  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  // Register/command layer side.
  modport master (
    input  rx_data,
    input  rx_valid,
    input  tx_ready,
    output tx_data,
    output tx_valid
  );

  // Bit-engine side.
  modport slave (
    output rx_data,
    output rx_valid,
    output tx_ready,
    input  tx_data,
    input  tx_valid
  );

endinterface

// File: rtl/spi_slave_shifter_tx_holding_reg.sv
// spi_tx_holding_reg: single-entry TX buffer between the command layer and
// the MISO shift register. It accepts a word when empty and releases it on
// the load strobe; an empty buffer hands out IDLE_TX instead. A word offered
// while the buffer is empty is captured even if a load happens in the same
// cycle, so that load sees the old (empty) contents and the new word waits
// for the next load point.
module spi_tx_holding_reg
  import spi_pkg::*;
#(
  parameter int                DATA_W  = SPI_DATA_W_DEFAULT,
  parameter logic [DATA_W-1:0] IDLE_TX = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              load,
  output logic [DATA_W-1:0] load_word
);

  logic              full;
  logic [DATA_W-1:0] held;
  logic              accept;

  assign accept    = tx_valid && !full;
  assign tx_ready  = !full;
  assign load_word = full ? held : IDLE_TX;

  // Capture an offered word when empty; a load empties a full buffer.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      full <= 1'b0;
      held <= '0;
    end else if (accept) begin
      full <= 1'b1;
      held <= tx_data;
    end else if (load) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_slave_shifter.sv
// spi_slave_shifter: SPI slave bit engine fed by single-cycle SCLK edge
// pulses. Deserialises MOSI into words for the layer above and serialises
// buffered TX words onto a registered MISO.
// Optional feature macro: SPI_SLAVE_ERR_FLAGS_EN enables the tx_underrun and
// rx_abort pulses; without it both outputs are constant 0.
module spi_slave_shifter
  import spi_pkg::*;
#(
  parameter int                DATA_W    = SPI_DATA_W_DEFAULT,
  parameter int                CPOL      = 0,
  parameter int                CPHA      = 0,
  parameter int                MSB_FIRST = 1,
  parameter logic [DATA_W-1:0] IDLE_TX   = '0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     sclk_rise,
  input  logic                     sclk_fall,
  input  logic                     cs_n,
  input  logic                     mosi,
  output logic                     miso,
  spi_slave_shifter_if.slave       bus,
  output logic                     busy,
  output logic                     tx_underrun,
  output logic                     rx_abort
);

  localparam bit SAMPLE_RISE = sample_on_rise(CPOL, CPHA);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  spi_state_e        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_sh;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] tx_next;
  logic [DATA_W-1:0] load_word;
  logic              hold_ready;
  logic              edge_ok;
  logic              sample_edge;
  logic              shift_edge;
  logic              load_pt;

  // Bit that appears on MISO for a given shift-register value.
  function automatic logic out_bit(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
  endfunction

  // Shift one bit into a word from the end opposite the outgoing bit.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w,
                                                 input logic b);
    return (MSB_FIRST != 0) ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
  endfunction

  // Edges only count inside a frame, and a simultaneous rise+fall is noise.
  assign edge_ok     = !cs_n && !(sclk_rise && sclk_fall);
  assign sample_edge = edge_ok && (SAMPLE_RISE ? sclk_rise : sclk_fall);
  assign shift_edge  = edge_ok && (SAMPLE_RISE ? sclk_fall : sclk_rise);
  assign rx_next     = shift_in(rx_sh, mosi);
  assign tx_next     = shift_in(tx_sh, 1'b0);

  // Load points: with CPHA=0 the first bit must be on MISO before the first
  // sample, so load at frame start and on the shift edge that closes a word
  // (the only shift edge seen at bit 0); with CPHA=1 the first shift edge of
  // each word is the load.
  always_comb begin
    load_pt = 1'b0;
    if (state == ST_IDLE) begin
      load_pt = !cs_n && (CPHA == 0);
    end else begin
      load_pt = shift_edge && (bit_cnt == '0);
    end
  end

  spi_tx_holding_reg #(
    .DATA_W  (DATA_W),
    .IDLE_TX (IDLE_TX)
  ) u_hold (
    .clk       (clk),
    .rstn      (rstn),
    .tx_data   (bus.tx_data),
    .tx_valid  (bus.tx_valid),
    .tx_ready  (hold_ready),
    .load      (load_pt),
    .load_word (load_word)
  );

  assign bus.tx_ready = hold_ready;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

  // Frame FSM with the RX/TX shift registers and all registered outputs;
  // chip select deassertion wins over any edge in the same cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      bit_cnt    <= '0;
      rx_sh      <= '0;
      tx_sh      <= '0;
      miso       <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!cs_n) begin
            state <= ST_SHIFT;
            busy  <= 1'b1;
            if (load_pt) begin
              tx_sh <= load_word;
              miso  <= out_bit(load_word);
            end
          end
        end
        ST_SHIFT: begin
          if (cs_n) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            bit_cnt <= '0;
            rx_sh   <= '0;
          end else begin
            if (sample_edge) begin
              rx_sh <= rx_next;
              if (bit_cnt == LAST_BIT) begin
                bit_cnt    <= '0;
                rx_data_q  <= rx_next;
                rx_valid_q <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            if (shift_edge) begin
              if (load_pt) begin
                tx_sh <= load_word;
                miso  <= out_bit(load_word);
              end else begin
                tx_sh <= tx_next;
                miso  <= out_bit(tx_next);
              end
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPI_SLAVE_ERR_FLAGS_EN
  // Flag loads that had nothing queued, and frames cut off mid-word.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_underrun <= 1'b0;
      rx_abort    <= 1'b0;
    end else begin
      tx_underrun <= load_pt && hold_ready;
      rx_abort    <= (state == ST_SHIFT) && cs_n && (bit_cnt != '0);
    end
  end
`else
  assign tx_underrun = 1'b0;
  assign rx_abort    = 1'b0;
`endif

endmodule
